// File: rtl/ps2_letter_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_letter_rx
// Description : PS/2 keyboard receiver that turns set-2 make codes for the
//               letter keys into a 5-bit letter index (0=A .. 25=Z).
//               Break (0xF0) and extended (0xE0) prefixes are tracked, and the
//               byte that follows either prefix is swallowed.
//               Framing: start 0, 8 data bits LSB first, odd parity, stop 1.
//               A frame that stalls for TIMEOUT_CYCLES clk_in cycles is
//               aborted with an error pulse.
// Ports       : clk_in           - system clock
//               rst_in           - asynchronous active-high reset
//               ps2_clk_in       - raw PS/2 clock pin (asynchronous)
//               ps2_data_in      - raw PS/2 data pin (asynchronous)
//               letter_out       - decoded letter, held between valid pulses
//               letter_valid_out - one-cycle pulse marking a new letter_out
//               error_out        - one-cycle pulse on parity/framing/timeout
// Options     : PS2_TYPEMATIC_FILTER_EN - when defined, a repeated make code
//               for the last emitted letter is suppressed until that key's
//               break code is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_letter_rx #(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [4:0] letter_out,
    output logic       letter_valid_out,
    output logic       error_out
);

    localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         c_BREAK   = 8'hF0;
    localparam logic [7:0]         c_EXT     = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers. They reset to 1, the idle level of both PS/2 lines,
    // so releasing reset never manufactures a falling edge.
    // ------------------------------------------------------------------
    logic r_ps2c_s1, r_ps2c_s2, r_ps2c_prev;
    logic r_ps2d_s1, r_ps2d_s2;
    logic w_fall;
    logic w_data;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ps2c_s1   <= 1'b1;
            r_ps2c_s2   <= 1'b1;
            r_ps2c_prev <= 1'b1;
            r_ps2d_s1   <= 1'b1;
            r_ps2d_s2   <= 1'b1;
        end else begin
            r_ps2c_s1   <= ps2_clk_in;
            r_ps2c_s2   <= r_ps2c_s1;
            r_ps2c_prev <= r_ps2c_s2;
            r_ps2d_s1   <= ps2_data_in;
            r_ps2d_s2   <= r_ps2d_s1;
        end
    end

    assign w_fall = r_ps2c_prev & ~r_ps2c_s2;
    assign w_data = r_ps2d_s2;

    // ------------------------------------------------------------------
    // Frame receiver. It emits at most one event per cycle: either a good
    // byte or an error, so the two output pulses derived from these events
    // can never coincide.
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [c_CNT_W-1:0] r_to_cnt;
    logic               r_parity;
    logic               r_evt_byte;
    logic               r_evt_err;
    logic [7:0]         r_byte;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_to_cnt   <= '0;
            r_parity   <= 1'b0;
            r_evt_byte <= 1'b0;
            r_evt_err  <= 1'b0;
            r_byte     <= 8'h00;
        end else begin
            r_evt_byte <= 1'b0;
            r_evt_err  <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        // A high level on an edge while idle is not a start bit
                        if (!w_data) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_parity <= w_data;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (w_data && (^{r_shift, r_parity})) begin
                            r_evt_byte <= 1'b1;
                            r_byte     <= r_shift;
                        end else begin
                            r_evt_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == c_TO_LAST) begin
                    r_state   <= S_IDLE;
                    r_to_cnt  <= '0;
                    r_evt_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Set-2 scan code to letter index. Bit 5 flags a letter key.
    // ------------------------------------------------------------------
    function automatic logic [5:0] f_decode(input logic [7:0] code);
        logic [5:0] v;
        case (code)
            8'h1C: v = {1'b1, 5'd0};
            8'h32: v = {1'b1, 5'd1};
            8'h21: v = {1'b1, 5'd2};
            8'h23: v = {1'b1, 5'd3};
            8'h24: v = {1'b1, 5'd4};
            8'h2B: v = {1'b1, 5'd5};
            8'h34: v = {1'b1, 5'd6};
            8'h33: v = {1'b1, 5'd7};
            8'h43: v = {1'b1, 5'd8};
            8'h3B: v = {1'b1, 5'd9};
            8'h42: v = {1'b1, 5'd10};
            8'h4B: v = {1'b1, 5'd11};
            8'h3A: v = {1'b1, 5'd12};
            8'h31: v = {1'b1, 5'd13};
            8'h44: v = {1'b1, 5'd14};
            8'h4D: v = {1'b1, 5'd15};
            8'h15: v = {1'b1, 5'd16};
            8'h2D: v = {1'b1, 5'd17};
            8'h1B: v = {1'b1, 5'd18};
            8'h2C: v = {1'b1, 5'd19};
            8'h3C: v = {1'b1, 5'd20};
            8'h2A: v = {1'b1, 5'd21};
            8'h1D: v = {1'b1, 5'd22};
            8'h22: v = {1'b1, 5'd23};
            8'h35: v = {1'b1, 5'd24};
            8'h1A: v = {1'b1, 5'd25};
            default: v = 6'd0;
        endcase
        return v;
    endfunction

    logic [5:0] w_decode;
    logic       w_hit;
    logic [4:0] w_letter;

    assign w_decode = f_decode(r_byte);
    assign w_hit    = w_decode[5];
    assign w_letter = w_decode[4:0];

    // ------------------------------------------------------------------
    // Byte interpreter and output registers. Prefix flags only change on
    // accepted bytes, so errors and timeouts leave them intact.
    // ------------------------------------------------------------------
    logic r_break;
    logic r_ext;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [4:0] r_last;
    logic       r_suppress;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            letter_out       <= 5'd0;
            letter_valid_out <= 1'b0;
            error_out        <= 1'b0;
            r_break          <= 1'b0;
            r_ext            <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            r_last           <= 5'd0;
            r_suppress       <= 1'b0;
`endif
        end else begin
            letter_valid_out <= 1'b0;
            error_out        <= r_evt_err;
            if (r_evt_byte) begin
                if (r_byte == c_BREAK) begin
                    r_break <= 1'b1;
                end else if (r_byte == c_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_break || r_ext) begin
                    r_break <= 1'b0;
                    r_ext   <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                    // Release of the repeating (non-extended) key re-arms it
                    if (r_break && !r_ext && w_hit && (w_letter == r_last)) begin
                        r_suppress <= 1'b0;
                    end
`endif
                end else if (w_hit) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (!(r_suppress && (w_letter == r_last))) begin
                        letter_out       <= w_letter;
                        letter_valid_out <= 1'b1;
                        r_last           <= w_letter;
                        r_suppress       <= 1'b1;
                    end
`else
                    letter_out       <= w_letter;
                    letter_valid_out <= 1'b1;
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_letter_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_letter_rx
// Description : Self-checking bench for ps2_letter_rx. A byte-level model
//               predicts each output pulse (kind, letter, cycle) and a single
//               compare process checks the outputs every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_letter_rx;

    localparam int TO = 100;   // timeout used for the DUT instance
    localparam int H  = 20;    // PS/2 half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [4:0] letter_out;
    logic       letter_valid_out;
    logic       error_out;

    ps2_letter_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .ps2_clk_in      (ps2c),
        .ps2_data_in     (ps2d),
        .letter_out      (letter_out),
        .letter_valid_out(letter_valid_out),
        .error_out       (error_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int letter;
        int at;
        int tol;
    } ev_t;

    ev_t        q[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_letter = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         lut[256];
    logic [7:0] codes[26];
    bit         brk = 0, ext = 0, sup = 0;
    int         last_letter = 0;
    int         last_fall = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte level) ----------------
    task automatic push_ev(input bit is_err, input int letter, input int at, input int tol);
        ev_t e;
        e.is_err = is_err; e.letter = letter; e.at = at; e.tol = tol;
        q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] v, input bit ok, input int c);
        int l;
        l = lut[v];
        if (!ok) push_ev(1, 0, c + 4, 0);
        else if (v == 8'hF0) brk = 1;
        else if (v == 8'hE0) ext = 1;
        else if (brk || ext) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (brk && !ext && l >= 0 && l == last_letter) sup = 0;
`endif
            brk = 0; ext = 0;
        end else if (l >= 0) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!(sup && l == last_letter)) begin
                push_ev(0, l, c + 4, 0);
                last_letter = l; sup = 1;
            end
`else
            push_ev(0, l, c + 4, 0);
`endif
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            q.delete();
            exp_letter = 0;
        end else begin
            if (letter_valid_out && error_out)
                chk("valid_and_error_together", 1, 0);
            if (letter_valid_out || error_out) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse_valid", int'(letter_valid_out), 0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind_is_error", int'(error_out), int'(e.is_err));
                    chk("pulse_cycle_late", (cyc > e.at + e.tol) ? 1 : 0, 0);
                    chk("pulse_cycle_early", (cyc < e.at - e.tol) ? 1 : 0, 0);
                    if (!e.is_err) exp_letter = e.letter;
                    if (letter_valid_out) n_valid++;
                    if (error_out) n_err++;
                end
            end else if (q.size() > 0 && cyc > q[0].at + q[0].tol) begin
                chk("missing_pulse_expected_error", int'(q[0].is_err), -1);
                void'(q.pop_front());
            end
            chk("letter_out", int'(letter_out), exp_letter);
        end
    end

    // ---------------- PS/2 driver ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input bit b);
        ps2d = b;
        wait_clks(H);
        ps2c = 1'b0;
        last_fall = cyc;
        wait_clks(H);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] v, input bit bad_par = 0, input bit bad_stop = 0);
        bit par;
        par = (~^v) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(v[i]);
        ps2_bit(par);
        ps2d = ~bad_stop;
        wait_clks(H);
        ps2c = 1'b0;
        model_byte(v, !bad_par && !bad_stop, cyc);
        wait_clks(H);
        ps2c = 1'b1;
        ps2d = 1'b1;
        wait_clks(2 * H);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v0, e0, r;
        logic [7:0] v;
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        for (int i = 0; i < 256; i++) lut[i] = -1;
        for (int i = 0; i < 26; i++) lut[codes[i]] = i;

        // Reset state
        wait_clks(5);
        chk("reset_letter_out", int'(letter_out), 0);
        chk("reset_valid", int'(letter_valid_out), 0);
        chk("reset_error", int'(error_out), 0);
        rst = 1'b0;
        wait_clks(10);

        // 0x1C -> A
        v0 = n_valid;
        send_frame(8'h1C);
        chk("A_pulses", n_valid - v0, 1);
        chk("A_letter", int'(letter_out), 0);

        // 0x1A, F0, 1A -> one Z
        v0 = n_valid;
        send_frame(8'h1A); send_frame(8'hF0); send_frame(8'h1A);
        chk("Z_break_pulses", n_valid - v0, 1);
        chk("Z_letter", int'(letter_out), 25);

        // 0x15 with flipped parity
        v0 = n_valid; e0 = n_err;
        send_frame(8'h15, 1);
        chk("parity_err_pulses", n_err - e0, 1);
        chk("parity_err_valid", n_valid - v0, 0);
        chk("parity_err_letter_held", int'(letter_out), 25);

        // Clock stops after 4 data bits
        e0 = n_err;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
        push_ev(1, 0, last_fall + 4 + TO, 1);
        ps2d = 1'b1;
        wait_clks(TO + 20);
        chk("timeout_err_pulses", n_err - e0, 1);
        send_frame(8'h21);
        chk("after_timeout_letter", int'(letter_out), 2);

        // E0, 1C, 24 -> only E
        v0 = n_valid;
        send_frame(8'hE0); send_frame(8'h1C); send_frame(8'h24);
        chk("ext_pulses", n_valid - v0, 1);
        chk("ext_letter", int'(letter_out), 4);

        // Typematic repeat
        v0 = n_valid;
        send_frame(8'h1C); send_frame(8'h1C); send_frame(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("repeat_pulses", n_valid - v0, 1);
`else
        chk("repeat_pulses", n_valid - v0, 3);
`endif
        chk("repeat_letter", int'(letter_out), 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      v = codes[$urandom_range(0, 25)];
            else if (r < 70) v = 8'hF0;
            else if (r < 78) v = 8'hE0;
            else             v = 8'($urandom_range(0, 255));
            send_frame(v, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        end

        // Make letter_out non-zero, then reset mid-frame
        send_frame(8'h1C);
        send_frame(8'h35);
`ifndef PS2_TYPEMATIC_FILTER_EN
        chk("pre_reset_letter", int'(letter_out), 24);
`endif
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        brk = 0; ext = 0; sup = 0; last_letter = 0;
        #1;
        chk("async_reset_letter", int'(letter_out), 0);
        chk("async_reset_valid", int'(letter_valid_out), 0);
        chk("async_reset_error", int'(error_out), 0);
        wait_clks(5);
        rst = 1'b0;
        wait_clks(20);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h24);
        chk("post_reset_pulses", n_valid - v0, 1);
        chk("post_reset_errors", n_err - e0, 0);
        chk("post_reset_letter", int'(letter_out), 4);

        wait_clks(TO + 20);
        chk("events_outstanding", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
